// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense path: sequencer states,
// fault codes and the event word layout used between the vending FSM and the queue.
package vend_pkg;

    localparam int unsigned COIN_W = 2;
    localparam int unsigned EV_W   = COIN_W + 1;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_LOAD     = 3'd1,
        SEQ_MOTOR    = 3'd2,
        SEQ_COIN_REQ = 3'd3,
        SEQ_COIN_REL = 3'd4,
        SEQ_FAULT    = 3'd5
    } seq_state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_MOTOR = 2'b01;
    localparam logic [1:0] FC_COIN  = 2'b10;

    typedef struct packed {
        logic              vend;
        logic [COIN_W-1:0] change;
    } vend_ev_t;

    // An event that asks for neither a product nor change carries no work.
    function automatic logic ev_is_null(input vend_ev_t ev);
        return !ev.vend && (ev.change == '0);
    endfunction

endpackage

// File: rtl/vend_event_fifo.sv
// Synchronous event queue with wrap-bit pointers; full/empty decode directly
// from the pointer registers so they never depend combinationally on push/pop.
module vend_event_fifo
    import vend_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = EV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Queues vend/change requests and runs the product motor and shared coin hopper
// one action at a time, latching a fault when an actuator stops responding.
module vend_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MOTOR_TIMEOUT = 255,
    parameter int unsigned COIN_TIMEOUT  = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ev_valid,
    input  logic              ev_vend,
    input  logic [COIN_W-1:0] ev_change,
    output logic              ev_ready,
    output logic              motor_on,
    input  logic              motor_done,
    output logic              coin_req,
    input  logic              coin_ack,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code,
    input  logic              fault_clr
);

    localparam logic [7:0]        MOTOR_LIMIT = 8'(MOTOR_TIMEOUT);
    localparam logic [7:0]        COIN_LIMIT  = 8'(COIN_TIMEOUT);
    localparam logic [7:0]        TIMER_ONE   = 8'd1;
    localparam logic [COIN_W-1:0] COIN_ONE    = COIN_W'(1);

    seq_state_e        state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic              cur_vend_q, cur_vend_d;
    logic [COIN_W-1:0] cur_coins_q, cur_coins_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic              motor_on_q;
    logic              coin_req_q;
    logic              fault_q;

    vend_ev_t in_ev;
    vend_ev_t head_ev;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;

    assign in_ev     = {ev_vend, ev_change};
    assign fifo_push = ev_valid && !fifo_full && !ev_is_null(in_ev);
    assign fifo_pop  = (state_q == SEQ_LOAD);

    vend_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (in_ev),
        .pop_i   (fifo_pop),
        .rdata_o (head_ev),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshake completion is tested before the timer in every waiting state.
    always_comb begin
        state_d      = state_q;
        cur_vend_d   = cur_vend_q;
        cur_coins_d  = cur_coins_q;
        fault_code_d = fault_code_q;
        case (state_q)
            SEQ_IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                cur_vend_d  = head_ev.vend;
                cur_coins_d = head_ev.change;
                state_d     = head_ev.vend ? SEQ_MOTOR : SEQ_COIN_REQ;
            end
            SEQ_MOTOR: begin
                if (motor_done) begin
                    state_d = (cur_coins_q != '0) ? SEQ_COIN_REQ : SEQ_IDLE;
                end else if (timer_q >= MOTOR_LIMIT) begin
                    state_d      = SEQ_FAULT;
                    fault_code_d = FC_MOTOR;
                end
            end
            SEQ_COIN_REQ: begin
                if (coin_ack) begin
                    cur_coins_d = cur_coins_q - COIN_ONE;
                    state_d     = SEQ_COIN_REL;
                end else if (timer_q >= COIN_LIMIT) begin
                    state_d      = SEQ_FAULT;
                    fault_code_d = FC_COIN;
                end
            end
            SEQ_COIN_REL: begin
                if (!coin_ack) begin
                    state_d = (cur_coins_q != '0) ? SEQ_COIN_REQ : SEQ_IDLE;
                end else if (timer_q >= COIN_LIMIT) begin
                    state_d      = SEQ_FAULT;
                    fault_code_d = FC_COIN;
                end
            end
            SEQ_FAULT: begin
                if (fault_clr) begin
                    state_d      = SEQ_IDLE;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_comb begin
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == SEQ_MOTOR || state_q == SEQ_COIN_REQ || state_q == SEQ_COIN_REL)) begin
            timer_d = timer_q + TIMER_ONE;
        end
    end

    // Actuator and fault outputs are decoded from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            timer_q      <= '0;
            cur_vend_q   <= 1'b0;
            cur_coins_q  <= '0;
            fault_code_q <= FC_NONE;
            motor_on_q   <= 1'b0;
            coin_req_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cur_vend_q   <= cur_vend_d;
            cur_coins_q  <= cur_coins_d;
            fault_code_q <= fault_code_d;
            motor_on_q   <= (state_d == SEQ_MOTOR);
            coin_req_q   <= (state_d == SEQ_COIN_REQ);
            fault_q      <= (state_d == SEQ_FAULT);
        end
    end

    assign ev_ready   = !fifo_full;
    assign busy       = (state_q != SEQ_IDLE) || !fifo_empty;
    assign motor_on   = motor_on_q;
    assign coin_req   = coin_req_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule
